// File: rtl/pattern_det_scheduler_if.sv
// Request/detect/readback bundle between bit-serial requesters and the shared
// pattern-detector scheduler.
interface pattern_det_scheduler_if #(
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]   req_valid;
  logic [NCH-1:0]   req_bit;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   clr_ch;
  logic             det_valid;
  logic [CHW-1:0]   det_ch;
  logic             det_hit;
  logic [CHW-1:0]   rd_sel;
  logic [CNT_W-1:0] rd_cnt;

  modport master (
    output req_valid, req_bit, clr_ch, rd_sel,
    input  req_ready, det_valid, det_ch, det_hit, rd_cnt
  );

  modport slave (
    input  req_valid, req_bit, clr_ch, rd_sel,
    output req_ready, det_valid, det_ch, det_hit, rd_cnt
  );
endinterface

// File: rtl/pattern_det_scheduler.sv
// One serial pattern detector time-shared round-robin among NCH bit-serial
// channels, with per-channel detector context and saturating hit counters.
module pattern_det_scheduler #(
  parameter int                 NCH     = 4,
  parameter int                 CHW     = 2,
  parameter int                 PAT_LEN = 2,
  parameter logic [PAT_LEN-1:0] PATTERN = 2'b01,
  parameter int                 CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pattern_det_scheduler_if.slave bus
);
  localparam int               FW       = $clog2(PAT_LEN);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Per-channel detector context.
  logic [PAT_LEN-2:0] r_hist [NCH];
  logic [FW-1:0]      r_fill [NCH];
  logic [CNT_W-1:0]   r_cnt  [NCH];

  logic [CHW-1:0]     r_ptr;
  logic               r_det_valid;
  logic [CHW-1:0]     r_det_ch;
  logic               r_det_hit;

  logic [NCH-1:0]     w_elig;
  logic [NCH-1:0]     w_grant;
  logic [CHW-1:0]     w_gidx;
  logic               w_accept;
  logic               w_bit;
  logic [PAT_LEN-1:0] w_win;
  logic               w_hit;

  function automatic logic [CHW-1:0] wrap_idx(input int v);
    return CHW'(v % NCH);
  endfunction

  // A channel being cleared must not have its bit consumed.
  assign w_elig = bus.req_valid & ~bus.clr_ch;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_accept = 1'b0;
    w_gidx   = '0;
    w_grant  = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!w_accept && w_elig[wrap_idx(int'(r_ptr) + k)]) begin
        w_accept = 1'b1;
        w_gidx   = wrap_idx(int'(r_ptr) + k);
      end
    end
    if (w_accept) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign bus.req_ready = w_grant;

  assign w_bit = bus.req_bit[w_gidx];
  assign w_win = {r_hist[w_gidx], w_bit};
  assign w_hit = w_accept && (r_fill[w_gidx] == FILL_MAX) && (w_win == PATTERN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= CHW'(NCH - 1);
    end else if (w_accept) begin
      r_ptr <= w_gidx;
    end
  end

  // Result stage: channel/hit hold their last values when no bit was accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_det_valid <= 1'b0;
      r_det_ch    <= '0;
      r_det_hit   <= 1'b0;
    end else begin
      r_det_valid <= w_accept;
      if (w_accept) begin
        r_det_ch  <= w_gidx;
        r_det_hit <= w_hit;
      end
    end
  end

  assign bus.det_valid = r_det_valid;
  assign bus.det_ch    = r_det_ch;
  assign bus.det_hit   = r_det_hit;

  // The counter follows the reported result, so a clear arriving while that
  // result is in flight wins and the increment is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_hist[c] <= '0;
        r_fill[c] <= '0;
        r_cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.clr_ch[c]) begin
          r_hist[c] <= '0;
          r_fill[c] <= '0;
          r_cnt[c]  <= '0;
        end else begin
          if (w_accept && (int'(w_gidx) == c)) begin
            r_hist[c] <= w_win[PAT_LEN-2:0];
            if (r_fill[c] != FILL_MAX) begin
              r_fill[c] <= r_fill[c] + 1'b1;
            end
          end
          if (r_det_valid && r_det_hit && (int'(r_det_ch) == c) && (r_cnt[c] != CNT_MAX)) begin
            r_cnt[c] <= r_cnt[c] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.rd_cnt = '0;
    if (int'(bus.rd_sel) < NCH) begin
      bus.rd_cnt = r_cnt[bus.rd_sel];
    end
  end
endmodule
